cpu_control: RTL and testbench
==============================

CPU_CONTROL -- requirements
Module: cpu_control

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port s  input  1  start request, sampled in WAIT.
REQ-004 SHALL have port load  input  1  instruction-register load enable.
REQ-005 SHALL have port in  input  16  instruction word.
REQ-006 SHALL have port w  output  1  idle flag; 1 only in WAIT.
REQ-007 SHALL have ports readnum, writenum  output  3  register selects.
REQ-008 SHALL have ports ALUop, shift  output  2  ALU operation and shifter code.
REQ-009 SHALL have ports asel, bsel, loada, loadb, loadc, loads, write  output  1  datapath strobes.
REQ-010 SHALL have port vsel  output  4  one-hot writeback select: 0001 C, 0010 PC, 0100 sximm8, 1000 mdata.
REQ-011 SHALL have ports sximm8, sximm5  output  16  sign-extended in[7:0] and in[4:0] of the held instruction.

Function
REQ-012 SHALL hold the instruction register (IR), loaded from in on clk when load=1 and state=WAIT; load is ignored in all other states.
REQ-013 SHALL decode the IR as opcode[15:13], op[12:11], Rn[10:8], Rd[7:5], sh[4:3], Rm[2:0].
REQ-014 SHALL implement states WAIT, DECODE, WRITE_IMM, GET_A, GET_B, ALU, WRITE_REG.
REQ-015 SHALL move from WAIT to DECODE when s=1; otherwise it SHALL stay in WAIT.
REQ-016 SHALL route DECODE as follows:
- 110/10 (MOV imm) -> WRITE_IMM.
- 110/00 (MOV reg) -> GET_B.
- 101/11 (MVN) -> GET_B.
- 101/00, 101/01, 101/10 (ADD, CMP, AND) -> GET_A.
- Any other opcode/op -> WAIT, with no strobes.
REQ-017 SHALL drive WRITE_IMM: writenum=Rn, vsel=0100, write=1; next state WAIT.
REQ-018 SHALL drive GET_A: readnum=Rn, loada=1; next state GET_B.
REQ-019 SHALL drive GET_B: readnum=Rm, loadb=1; next state ALU.
REQ-020 SHALL drive ALU: bsel=0, shift=sh.
- ALUop=op for opcode 101; ALUop=00 for MOV reg.
- asel=1 for MOV reg and MVN; asel=0 otherwise.
- CMP: loads=1, loadc=0, next state WAIT.
- All others: loadc=1, next state WRITE_REG.
REQ-021 SHALL drive WRITE_REG: writenum=Rd, vsel=0001, write=1; next state WAIT.
REQ-022 SHALL drive every strobe, readnum and writenum to 0, and vsel to 0001, in any state where REQ-017 to REQ-021 do not specify them.
REQ-023 SHALL produce all datapath outputs combinationally from state and IR (Moore).
REQ-024 SHALL have these latencies, counted in clk edges from the s-sampling edge back to w=1:
- MOV imm: 3.
- MOV reg, MVN, CMP: 5.
- ADD, AND: 6.
REQ-025 SHALL, if s=1 is held continuously, re-execute the held IR back-to-back, with w=1 for exactly one cycle between instructions.

Reset
REQ-026 SHALL, while reset=1, force state=WAIT, IR=0, w=1, and all strobes=0, independent of clk.
REQ-027 SHALL abandon any in-flight instruction on reset, with no further write, loadc or loads.

Structure
REQ-028 SHALL take the state enum, the opcode/op constants and the vsel one-hot constants from shared package cpu_pkg.
REQ-029 SHALL place field extraction and sign extension in combinational sub-module instr_dec; the FSM and IR stay in cpu_control.
REQ-030 The top level SHALL tie the datapath mdata and PC inputs to 0.

Verification
REQ-031 Bench SHALL cover MOV imm: IR=0xD007, s pulse -> WRITE_IMM cycle shows writenum=0, vsel=0100, sximm8=0x0007, write=1; w=1 again 3 edges after s.
REQ-032 Bench SHALL cover negative immediate: IR=0xD1FE -> sximm8=0xFFFE, writenum=1.
REQ-033 Bench SHALL cover ADD: IR=0xA148 (ADD R2,R1,R0,LSL#1) -> sequence:
- GET_A: readnum=1, loada.
- GET_B: readnum=0, loadb.
- ALU: shift=01, ALUop=00, asel=0, loadc.
- WRITE_REG: writenum=2, vsel=0001, write.
- w=1 after 6 edges.
REQ-034 Bench SHALL cover CMP: IR=0xA801 -> ALU cycle shows ALUop=01, loads=1, loadc=0; write never asserted; 5-edge latency.
REQ-035 Bench SHALL cover reset and load-while-busy:
- Reset asserted mid-GET_B -> immediate WAIT, w=1, all strobes 0.
- load=1 with in=0xD0FF during ALU state -> IR unchanged.
REQ-036 Bench SHALL cover an unsupported opcode: IR=0xE000 -> DECODE then WAIT; no write, loadc or loads.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU control unit: FSM state names,
// opcode/op field values and the one-hot writeback select codes.
package cpu_pkg;

   // Controller states; WAIT is the only idle state
   typedef enum logic [2:0] {
      S_WAIT      = 3'd0,
      S_DECODE    = 3'd1,
      S_WRITE_IMM = 3'd2,
      S_GET_A     = 3'd3,
      S_GET_B     = 3'd4,
      S_ALU       = 3'd5,
      S_WRITE_REG = 3'd6
   } state_t;

   // Instruction classes (opcode field, IR[15:13])
   localparam logic [2:0] OPC_MOV = 3'b110;
   localparam logic [2:0] OPC_ALU = 3'b101;

   // Sub-operation (op field, IR[12:11]); MOV and ALU classes share the encoding space
   localparam logic [1:0] OP_MOV_REG = 2'b00;
   localparam logic [1:0] OP_MOV_IMM = 2'b10;
   localparam logic [1:0] OP_ADD     = 2'b00;
   localparam logic [1:0] OP_CMP     = 2'b01;
   localparam logic [1:0] OP_AND     = 2'b10;
   localparam logic [1:0] OP_MVN     = 2'b11;

   // One-hot writeback select driven to the register-file input mux
   localparam logic [3:0] VSEL_C     = 4'b0001;
   localparam logic [3:0] VSEL_PC    = 4'b0010;
   localparam logic [3:0] VSEL_IMM   = 4'b0100;
   localparam logic [3:0] VSEL_MDATA = 4'b1000;

   // Where DECODE goes for a given opcode/op; unknown encodings fall back to WAIT
   function automatic state_t decodeNext(input logic [2:0] opcode, input logic [1:0] op);
      state_t nxt;
      nxt = S_WAIT;
      if (opcode == OPC_MOV && op == OP_MOV_IMM)
         nxt = S_WRITE_IMM;
      else if (opcode == OPC_MOV && op == OP_MOV_REG)
         nxt = S_GET_B;
      else if (opcode == OPC_ALU && op == OP_MVN)
         nxt = S_GET_B;
      else if (opcode == OPC_ALU && (op == OP_ADD || op == OP_CMP || op == OP_AND))
         nxt = S_GET_A;
      return nxt;
   endfunction

endpackage

// File: rtl/instr_dec.sv
// Instruction field splitter: pulls the register/opcode fields out of the
// held instruction and sign-extends the two immediates.
module instr_dec
   import cpu_pkg::*;
(
   input  logic [15:0] i_ir,
   output logic [2:0]  o_opcode,
   output logic [1:0]  o_op,
   output logic [2:0]  o_rn,
   output logic [2:0]  o_rd,
   output logic [1:0]  o_sh,
   output logic [2:0]  o_rm,
   output logic [15:0] o_sximm8,
   output logic [15:0] o_sximm5
);

   // Pure wiring of the fixed instruction layout plus sign extension
   always_comb begin
      o_opcode = i_ir[15:13];
      o_op     = i_ir[12:11];
      o_rn     = i_ir[10:8];
      o_rd     = i_ir[7:5];
      o_sh     = i_ir[4:3];
      o_rm     = i_ir[2:0];
      o_sximm8 = {{8{i_ir[7]}}, i_ir[7:0]};
      o_sximm5 = {{11{i_ir[4]}}, i_ir[4:0]};
   end

endmodule

// File: rtl/cpu_control.sv
// Multi-cycle CPU controller: holds the instruction register, steps the
// datapath through read/compute/writeback, and raises w when idle.
// This block owns no datapath, so the PC and mdata writeback sources it
// selects between are supplied as constant zero at the datapath level.
module cpu_control
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        s,
   input  logic        load,
   input  logic [15:0] in,
   output logic        w,
   output logic [2:0]  readnum,
   output logic [2:0]  writenum,
   output logic [1:0]  ALUop,
   output logic [1:0]  shift,
   output logic        asel,
   output logic        bsel,
   output logic        loada,
   output logic        loadb,
   output logic        loadc,
   output logic        loads,
   output logic        write,
   output logic [3:0]  vsel,
   output logic [15:0] sximm8,
   output logic [15:0] sximm5
);

   state_t      r_state;
   logic [15:0] r_ir;

   logic [2:0]  w_opcode;
   logic [1:0]  w_op;
   logic [2:0]  w_rn;
   logic [2:0]  w_rd;
   logic [1:0]  w_sh;
   logic [2:0]  w_rm;
   logic        w_isMovReg;
   logic        w_isMvn;
   logic        w_isCmp;

   instr_dec uDec (
      .i_ir     (r_ir),
      .o_opcode (w_opcode),
      .o_op     (w_op),
      .o_rn     (w_rn),
      .o_rd     (w_rd),
      .o_sh     (w_sh),
      .o_rm     (w_rm),
      .o_sximm8 (sximm8),
      .o_sximm5 (sximm5)
   );

   // Instruction-class flags used by the ALU-step decisions
   always_comb begin
      w_isMovReg = (w_opcode == OPC_MOV) && (w_op == OP_MOV_REG);
      w_isMvn    = (w_opcode == OPC_ALU) && (w_op == OP_MVN);
      w_isCmp    = (w_opcode == OPC_ALU) && (w_op == OP_CMP);
   end

   // State sequencing and IR capture; the IR only accepts a new word while idle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_WAIT;
         r_ir    <= '0;
      end else begin
         case (r_state)
            S_WAIT: begin
               if (load)
                  r_ir <= in;
               if (s)
                  r_state <= S_DECODE;
            end
            S_DECODE:    r_state <= decodeNext(w_opcode, w_op);
            S_WRITE_IMM: r_state <= S_WAIT;
            S_GET_A:     r_state <= S_GET_B;
            S_GET_B:     r_state <= S_ALU;
            S_ALU:       r_state <= w_isCmp ? S_WAIT : S_WRITE_REG;
            S_WRITE_REG: r_state <= S_WAIT;
            default:     r_state <= S_WAIT;
         endcase
      end
   end

   // Moore outputs: everything idles at zero (vsel at C) unless the state drives it
   always_comb begin
      w        = (r_state == S_WAIT);
      readnum  = '0;
      writenum = '0;
      ALUop    = '0;
      shift    = '0;
      asel     = 1'b0;
      bsel     = 1'b0;
      loada    = 1'b0;
      loadb    = 1'b0;
      loadc    = 1'b0;
      loads    = 1'b0;
      write    = 1'b0;
      vsel     = VSEL_C;
      case (r_state)
         S_WRITE_IMM: begin
            writenum = w_rn;
            vsel     = VSEL_IMM;
            write    = 1'b1;
         end
         S_GET_A: begin
            readnum = w_rn;
            loada   = 1'b1;
         end
         S_GET_B: begin
            readnum = w_rm;
            loadb   = 1'b1;
         end
         S_ALU: begin
            shift = w_sh;
            ALUop = (w_opcode == OPC_ALU) ? w_op : 2'b00;
            asel  = w_isMovReg || w_isMvn;
            if (w_isCmp)
               loads = 1'b1;
            else
               loadc = 1'b1;
         end
         S_WRITE_REG: begin
            writenum = w_rd;
            vsel     = VSEL_C;
            write    = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_cpu_control.sv
// Self-checking bench for cpu_control: each instruction is expanded by a
// behavioural model into the list of per-cycle output sets it should produce.
module tb_cpu_control;

   logic        clk;
   logic        reset;
   logic        s;
   logic        load;
   logic [15:0] in;
   logic        w;
   logic [2:0]  readnum;
   logic [2:0]  writenum;
   logic [1:0]  ALUop;
   logic [1:0]  shift;
   logic        asel;
   logic        bsel;
   logic        loada;
   logic        loadb;
   logic        loadc;
   logic        loads;
   logic        write;
   logic [3:0]  vsel;
   logic [15:0] sximm8;
   logic [15:0] sximm5;

   int assertCount = 0;
   int failCount   = 0;

   // Output vector layout: {w, readnum, writenum, ALUop, shift, asel, bsel,
   // loada, loadb, loadc, loads, write, vsel}
   localparam logic [21:0] IDLE_VEC  = 22'h200001;
   localparam logic [21:0] NO_OP_MSK = 22'h3F87FF;

   typedef struct {
      logic [21:0] vec;
      bit          aluCycle;
   } expCycle_t;

   expCycle_t expTrace[$];

   cpu_control dut (
      .clk      (clk),
      .reset    (reset),
      .s        (s),
      .load     (load),
      .in       (in),
      .w        (w),
      .readnum  (readnum),
      .writenum (writenum),
      .ALUop    (ALUop),
      .shift    (shift),
      .asel     (asel),
      .bsel     (bsel),
      .loada    (loada),
      .loadb    (loadb),
      .loadc    (loadc),
      .loads    (loads),
      .write    (write),
      .vsel     (vsel),
      .sximm8   (sximm8),
      .sximm5   (sximm5)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [21:0] obsVec();
      return {w, readnum, writenum, ALUop, shift, asel, bsel,
              loada, loadb, loadc, loads, write, vsel};
   endfunction

   function automatic logic [21:0] mk(input logic [2:0] rdNum, input logic [2:0] wrNum,
                                      input logic [1:0] aluOp, input logic [1:0] sh,
                                      input logic aSel, input logic ldA, input logic ldB,
                                      input logic ldC, input logic ldS, input logic wr,
                                      input logic [3:0] vs);
      return {1'b0, rdNum, wrNum, aluOp, sh, aSel, 1'b0, ldA, ldB, ldC, ldS, wr, vs};
   endfunction

   function automatic void push(input logic [21:0] v, input bit alu);
      expCycle_t e;
      e.vec      = v;
      e.aluCycle = alu;
      expTrace.push_back(e);
   endfunction

   function automatic logic [15:0] sext(input int value, input int bits);
      int v;
      v = value;
      if (v >= (1 << (bits - 1)))
         v = v - (1 << bits);
      return 16'(v);
   endfunction

   // Reference model: expected non-idle cycles for one instruction
   function automatic void buildTrace(input logic [15:0] ir);
      int opc, op, rn, rd, sh, rm;
      opc = int'(ir) / 8192;
      op  = (int'(ir) / 2048) % 4;
      rn  = (int'(ir) / 256) % 8;
      rd  = (int'(ir) / 32) % 8;
      sh  = (int'(ir) / 8) % 4;
      rm  = int'(ir) % 8;
      expTrace.delete();
      push(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0001), 0);
      if (opc == 6 && op == 2) begin
         push(mk(0, 3'(rn), 0, 0, 0, 0, 0, 0, 0, 1, 4'b0100), 0);
      end else if ((opc == 6 && op == 0) || (opc == 5 && op == 3)) begin
         push(mk(3'(rm), 0, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0001), 0);
         push(mk(0, 0, (opc == 5) ? 2'(op) : 2'd0, 2'(sh), 1, 0, 0, 1, 0, 0, 4'b0001), 1);
         push(mk(0, 3'(rd), 0, 0, 0, 0, 0, 0, 0, 1, 4'b0001), 0);
      end else if (opc == 5) begin
         push(mk(3'(rn), 0, 0, 0, 0, 1, 0, 0, 0, 0, 4'b0001), 0);
         push(mk(3'(rm), 0, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0001), 0);
         if (op == 1) begin
            push(mk(0, 0, 2'd1, 2'(sh), 0, 0, 0, 0, 1, 0, 4'b0001), 1);
         end else begin
            push(mk(0, 0, 2'(op), 2'(sh), 0, 0, 0, 1, 0, 0, 4'b0001), 1);
            push(mk(0, 3'(rd), 0, 0, 0, 0, 0, 0, 0, 1, 4'b0001), 0);
         end
      end
   endfunction

   // Latency table: clock edges from the s-sampling edge back to idle
   function automatic int expLatency(input logic [15:0] ir);
      int opc, op;
      opc = int'(ir) / 8192;
      op  = (int'(ir) / 2048) % 4;
      if (opc == 6 && op == 2)                    return 3;
      if (opc == 6 && op == 0)                    return 5;
      if (opc == 5 && (op == 3 || op == 1))       return 5;
      if (opc == 5 && (op == 0 || op == 2))       return 6;
      return 2;
   endfunction

   // Counts one comparison and reports it when observed differs from expected
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Loads one instruction, pulses s and follows it cycle by cycle back to idle;
   // with busyLoad set, load is held high with a different word the whole time
   task automatic applyStimulus(input logic [15:0] ir, input bit busyLoad, input string tag);
      int edges;
      int k;
      logic [21:0] obs;
      logic [21:0] expv;
      buildTrace(ir);
      @(negedge clk);
      load = 1'b1;
      in   = ir;
      s    = 1'b0;
      checkOutput({tag, " idle before"}, 32'(obsVec()), 32'(IDLE_VEC));
      @(negedge clk);
      load = 1'b0;
      s    = 1'b1;
      checkOutput({tag, " sximm8"}, 32'(sximm8), 32'(sext(int'(ir) % 256, 8)));
      checkOutput({tag, " sximm5"}, 32'(sximm5), 32'(sext(int'(ir) % 32, 5)));
      edges = 0;
      k     = 0;
      while (edges < 20) begin
         @(negedge clk);
         edges++;
         s = 1'b0;
         if (busyLoad) begin
            load = 1'b1;
            in   = 16'hD0FF;
         end
         if (w)
            break;
         if (k < expTrace.size()) begin
            obs  = obsVec();
            expv = expTrace[k].vec;
            if (!expTrace[k].aluCycle) begin
               obs  = obs & NO_OP_MSK;
               expv = expv & NO_OP_MSK;
            end
            checkOutput($sformatf("%s cycle%0d", tag, k), 32'(obs), 32'(expv));
         end
         k++;
      end
      load = 1'b0;
      checkOutput({tag, " latency"}, 32'(edges), 32'(expLatency(ir)));
      checkOutput({tag, " idle after"}, 32'(obsVec()), 32'(IDLE_VEC));
      checkOutput({tag, " IR kept"}, 32'(sximm8), 32'(sext(int'(ir) % 256, 8)));
   endtask

   // Holds s high: idle must appear for exactly one cycle between repeats
   task automatic runBackToBack(input logic [15:0] ir, input string tag);
      int lat;
      int edges;
      lat = expLatency(ir);
      @(negedge clk);
      load = 1'b1;
      in   = ir;
      @(negedge clk);
      load = 1'b0;
      s    = 1'b1;
      for (int i = 1; i <= 2 * lat + 1; i++) begin
         @(negedge clk);
         checkOutput($sformatf("%s w@%0d", tag, i), 32'(w), 32'((i % lat) == 0));
      end
      s = 1'b0;
      edges = 0;
      while (!w && edges < 20) begin
         @(negedge clk);
         edges++;
      end
      checkOutput({tag, " drain"}, 32'(w), 32'd1);
   endtask

   // Asserts reset in the middle of an ADD's GET_B step
   task automatic resetMidInstr();
      @(negedge clk);
      load = 1'b1;
      in   = 16'hA148;
      @(negedge clk);
      load = 1'b0;
      s    = 1'b1;
      @(negedge clk);
      s = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checkOutput("rst in GET_B", 32'({readnum, loadb}), 32'({3'd0, 1'b1}));
      #2 reset = 1'b1;
      #1;
      checkOutput("rst immediate", 32'(obsVec()), 32'(IDLE_VEC));
      checkOutput("rst IR clear", 32'(sximm8), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput($sformatf("rst held%0d", i), 32'(obsVec()), 32'(IDLE_VEC));
      end
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput($sformatf("rst after%0d", i), 32'(obsVec()), 32'(IDLE_VEC));
      end
   endtask

   // Top-level sequence: reset, directed instructions, then randomized ones
   initial begin
      logic [15:0] bases[6];
      logic [15:0] ir;
      int pick;
      bases[0] = 16'hD000;
      bases[1] = 16'hC000;
      bases[2] = 16'hB800;
      bases[3] = 16'hA000;
      bases[4] = 16'hA800;
      bases[5] = 16'hB000;
      reset = 1'b1;
      s     = 1'b0;
      load  = 1'b0;
      in    = 16'h0000;
      #3;
      checkOutput("reset outputs", 32'(obsVec()), 32'(IDLE_VEC));
      checkOutput("reset IR", 32'(sximm8), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      applyStimulus(16'hD007, 1'b0, "MOV imm");
      applyStimulus(16'hD1FE, 1'b0, "MOV neg imm");
      applyStimulus(16'hA148, 1'b0, "ADD");
      applyStimulus(16'hA801, 1'b0, "CMP");
      applyStimulus(16'hE000, 1'b0, "unsupported");
      applyStimulus(16'hC0EA, 1'b0, "MOV reg");
      applyStimulus(16'hB8B3, 1'b0, "MVN");
      applyStimulus(16'hB265, 1'b0, "AND");
      applyStimulus(16'hA148, 1'b1, "ADD busy load");
      resetMidInstr();
      runBackToBack(16'hD2F0, "b2b MOV imm");
      runBackToBack(16'hA801, "b2b CMP");

      for (int t = 0; t < 40; t++) begin
         pick = $urandom_range(0, 7);
         if (pick < 6)
            ir = bases[pick] | 16'($urandom_range(0, 16'h07FF));
         else
            ir = 16'($urandom);
         applyStimulus(ir, 1'($urandom_range(0, 1)), $sformatf("rand%0d ir=%h", t, ir));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
